// File: rtl/sdram_tb_pkg.sv
// Shared definitions for the SDRAM self-test: FSM states and the address-derived
// data pattern used by both the pattern writer and the read-back checker.
package sdram_tb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam logic [31:0] SEED_DEFAULT = 32'h5A5A_0000;

    // Callers truncate to their DATA_W; address and seed arrive zero-extended.
    function automatic logic [63:0] exp_word(input logic [63:0] addr, input logic [63:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/sdram_rd_checker_if.sv
// Burst read port between the read-back checker (master) and the SDRAM controller (slave).
interface sdram_rd_checker_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_req, rd_addr, input rd_ack, rd_valid, rd_data);
    modport slave  (input rd_req, rd_addr, output rd_ack, rd_valid, rd_data);
endinterface

// File: rtl/sdram_rd_checker.sv
// Sweeps [0, WORD_COUNT) in bursts through the controller read port and compares
// every returned beat against the shared address pattern.
module sdram_rd_checker
    import sdram_tb_pkg::*;
#(
    parameter int          ADDR_W     = 21,
    parameter int          DATA_W     = 32,
    parameter int          BURST_LEN  = 8,
    parameter int          WORD_COUNT = 2097152,
    parameter logic [31:0] SEED       = SEED_DEFAULT,
    parameter int          TIMEOUT    = 1023
) (
    input  logic                clk_in,
    input  logic                zusr_key,
    input  logic                start,
    sdram_rd_checker_if.master  rd,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data
);

    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int                WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]   WC        = (ADDR_W + 1)'(WORD_COUNT);
    localparam logic [ADDR_W:0]   BL        = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

    state_e              state, next_state;
    logic [ADDR_W-1:0]   base;
    logic [BEAT_W-1:0]   beat;
    logic [WD_W-1:0]     wd;
    logic [15:0]         err_q, err_next;
    logic [ADDR_W-1:0]   beat_addr;
    logic [DATA_W-1:0]   exp_data;
    logic                launch, beat_hit, burst_end, sweep_end, wd_expire, mism;

    assign beat_addr = base + ADDR_W'(beat);
    assign exp_data  = DATA_W'(exp_word(64'(beat_addr), 64'(SEED)));
    assign mism      = beat_hit && (rd.rd_data != exp_data);
    assign err_next  = (mism && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        beat_hit   = 1'b0;
        burst_end  = 1'b0;
        sweep_end  = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                launch     = 1'b1;
                next_state = REQ;
            end
            REQ: if (rd.rd_ack) next_state = WAIT;
            WAIT: begin
                if (rd.rd_valid) begin
                    beat_hit = 1'b1;
                    if (beat == LAST_BEAT) begin
                        burst_end = 1'b1;
                        // Extra sum bit lets a full 2^ADDR_W sweep end on base wrap.
                        sweep_end  = (({1'b0, base} + BL) == WC);
                        next_state = sweep_end ? DONE : REQ;
                    end
                end else if (wd == WD_LAST) begin
                    wd_expire  = 1'b1;
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge zusr_key) begin
        if (!zusr_key) state <= IDLE;
        else           state <= next_state;
    end

    always_ff @(posedge clk_in or negedge zusr_key) begin
        if (!zusr_key) begin
            base           <= '0;
            beat           <= '0;
            wd             <= '0;
            err_q          <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
        end else begin
            if (launch) begin
                base           <= '0;
                err_q          <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
                timeout        <= 1'b0;
                pass           <= 1'b0;
            end
            if (state == REQ && rd.rd_ack) begin
                beat <= '0;
                wd   <= '0;
            end
            if (beat_hit) begin
                beat  <= beat + 1'b1;
                wd    <= '0;
                err_q <= err_next;
                if (mism && err_q == 16'd0) begin
                    first_err_addr <= beat_addr;
                    first_err_data <= rd.rd_data;
                end
                if (burst_end) begin
                    if (sweep_end) pass <= (err_next == 16'd0);
                    else           base <= base + ADDR_W'(BURST_LEN);
                end
            end
            if (state == WAIT && !rd.rd_valid) begin
                wd <= wd + 1'b1;
                if (wd_expire) timeout <= 1'b1;
            end
        end
    end

    assign rd.rd_req  = (state == REQ);
    assign rd.rd_addr = base;
    assign busy       = (state == REQ) || (state == WAIT);
    assign done       = (state == DONE);
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_sdram_rd_checker.sv
// Directed bench: a small controller model serves the sweep; request addresses are
// queued when a sweep is started and popped as the checker issues requests.
module tb_sdram_rd_checker;

    localparam int AW = 21;
    localparam int DW = 32;

    logic clk_in = 1'b0;
    logic zusr_key;
    logic start;
    logic busy, done, pass, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    int vectors     = 0;
    int miscompares = 0;
    logic [AW-1:0] addr_q[$];

    sdram_rd_checker_if #(.ADDR_W(AW), .DATA_W(DW)) rd ();

    sdram_rd_checker #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(8), .WORD_COUNT(32),
        .SEED(32'h5A5A_0000), .TIMEOUT(15)
    ) dut (
        .clk_in(clk_in), .zusr_key(zusr_key), .start(start), .rd(rd),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr), .first_err_data(first_err_data)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end of run, expected summary before 200000");
        $fatal(1, "bench time limit expired");
    end

    function automatic logic [31:0] expd(input int a);
        return 32'(a) ^ 32'h5A5A_0000;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic go();
        addr_q.delete();
        for (int i = 0; i < 4; i++) addr_q.push_back(AW'(i * 8));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Serves up to 4 bursts; returns early before beat stop_k of burst stop_b.
    task automatic serve(input int ack_dly, input logic [31:0] corrupt, input int stop_b,
                         input int stop_k, input bit stray, input bit mid_start, input bit preload);
        for (int b = 0; b < 4; b++) begin
            int n;
            logic [AW-1:0] ea;
            n = 0;
            while (!rd.rd_req && n < 40) begin
                tick();
                n++;
            end
            chk("rd_req_seen", 64'(rd.rd_req), 64'(1));
            if (!rd.rd_req) return;
            ea = (addr_q.size() > 0) ? addr_q.pop_front() : '1;
            chk("rd_addr", 64'(rd.rd_addr), 64'(ea));
            for (int d = 0; d < ack_dly; d++) begin
                if (stray && d == 1) begin
                    rd.rd_valid = 1'b1;
                    rd.rd_data  = 32'hDEAD_BEEF;
                end
                tick();
                rd.rd_valid = 1'b0;
                chk("addr_stable", 64'(rd.rd_addr), 64'(ea));
                chk("req_held", 64'(rd.rd_req), 64'(1));
            end
            rd.rd_ack = 1'b1;
            tick();
            rd.rd_ack = 1'b0;
            if (preload && b == 0) begin
                force dut.err_q = 16'hFFFE;
                tick();
                release dut.err_q;
            end
            for (int k = 0; k < 8; k++) begin
                int w;
                if (b == stop_b && k == stop_k) return;
                if (mid_start && b == 1 && k == 2) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                w = b * 8 + k;
                rd.rd_valid = 1'b1;
                rd.rd_data  = expd(w) ^ {31'b0, corrupt[w]};
                tick();
                rd.rd_valid = 1'b0;
            end
        end
    endtask

    initial begin
        zusr_key    = 1'b0;
        start       = 1'b0;
        rd.rd_ack   = 1'b0;
        rd.rd_valid = 1'b0;
        rd.rd_data  = '0;
        repeat (2) tick();
        chk("rst_rd_req", 64'(rd.rd_req), 64'(0));
        chk("rst_rd_addr", 64'(rd.rd_addr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_pass", 64'(pass), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_first_addr", 64'(first_err_addr), 64'(0));
        chk("rst_first_data", 64'(first_err_data), 64'(0));
        zusr_key = 1'b1;
        tick();
        chk("idle_no_req", 64'(rd.rd_req), 64'(0));

        // Clean sweep
        go();
        serve(0, 32'h0, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("clean_done", 64'(done), 64'(1));
        chk("clean_pass", 64'(pass), 64'(1));
        chk("clean_err", 64'(err_cnt), 64'(0));
        chk("clean_req_count", 64'(addr_q.size()), 64'(0));
        repeat (3) tick();
        chk("clean_no_req", 64'(rd.rd_req), 64'(0));
        chk("clean_done_hold", 64'(done), 64'(1));

        // Corruption at words 13 and 20
        go();
        chk("restart_cleared_pass", 64'(pass), 64'(0));
        serve(0, 32'h0010_2000, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("corr_done", 64'(done), 64'(1));
        chk("corr_err", 64'(err_cnt), 64'(2));
        chk("corr_first_addr", 64'(first_err_addr), 64'(13));
        chk("corr_first_data", 64'(first_err_data), 64'(32'h5A5A_000C));
        chk("corr_pass", 64'(pass), 64'(0));

        // Watchdog: stop after 3 beats of burst 2
        go();
        serve(0, 32'h0, 2, 3, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("wd_not_yet", 64'({timeout, done}), 64'(0));
        end
        tick();
        chk("wd_timeout", 64'(timeout), 64'(1));
        chk("wd_done", 64'(done), 64'(1));
        chk("wd_pass", 64'(pass), 64'(0));
        chk("wd_rd_req", 64'(rd.rd_req), 64'(0));
        chk("wd_busy", 64'(busy), 64'(0));

        // Delayed ack, stray beat in REQ, start mid-WAIT
        go();
        chk("restart_cleared_timeout", 64'(timeout), 64'(0));
        serve(5, 32'h0, -1, -1, 1'b1, 1'b1, 1'b0);
        chk("dly_done", 64'(done), 64'(1));
        chk("dly_pass", 64'(pass), 64'(1));
        chk("dly_err", 64'(err_cnt), 64'(0));
        chk("dly_req_count", 64'(addr_q.size()), 64'(0));

        // Reset during WAIT of burst 1
        go();
        serve(0, 32'h0000_0008, 1, 2, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_err", 64'(err_cnt), 64'(1));
        chk("pre_rst_busy", 64'(busy), 64'(1));
        zusr_key = 1'b0;
        #1;
        chk("async_rd_req", 64'(rd.rd_req), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_err", 64'(err_cnt), 64'(0));
        chk("async_first_addr", 64'(first_err_addr), 64'(0));
        repeat (2) tick();
        zusr_key = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", 64'({busy, done, rd.rd_req}), 64'(0));
        go();
        serve(0, 32'h0, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_done", 64'(done), 64'(1));
        chk("post_rst_pass", 64'(pass), 64'(1));

        // Saturation from a preloaded count
        go();
        serve(0, 32'hFFFF_FFFF, -1, -1, 1'b0, 1'b0, 1'b1);
        chk("sat_err", 64'(err_cnt), 64'(16'hFFFF));
        chk("sat_first_data", 64'(first_err_data), 64'(0));
        chk("sat_done", 64'(done), 64'(1));
        chk("sat_pass", 64'(pass), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
